// File: rtl/sar_lteq_search_pkg.sv
// Shared definitions for the successive-approximation <= search initiator:
// FSM state encoding, default operand width and timeout counter sizing.
package sar_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } state_t;

    // Width of a counter that must be able to hold the value 'limit'.
    // A limit of 0 still needs one bit so the counter is never zero-width.
    function automatic int ctr_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sar_lteq_search_if.sv
// Request/response link between the search initiator (master) and the
// comparator (slave): trial operand out, single lteq result bit back.
interface sar_lteq_search_if #(
    parameter int WIDTH = sar_pkg::DEFAULT_WIDTH
);
    logic             req_valid;
    logic [WIDTH-1:0] req_a;
    logic             rsp_valid;
    logic             rsp_lteq;

    modport master (
        output req_valid,
        output req_a,
        input  rsp_valid,
        input  rsp_lteq
    );

    modport slave (
        input  req_valid,
        input  req_a,
        output rsp_valid,
        output rsp_lteq
    );
endinterface

// File: rtl/sar_lteq_search_timeout_ctr.sv
// Per-request wait counter for request/response initiators. Counts enabled
// cycles after a clear and saturates at TIMEOUT; 'hit' is high while the
// stored count equals TIMEOUT. TIMEOUT=0 disables it (hit stays low).
module sar_timeout_ctr
    import sar_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);
    localparam int            CW    = ctr_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Count unanswered cycles; clear has priority, saturate at the limit.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (TIMEOUT != 0) && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign hit = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/sar_lteq_search.sv
// Successive-approximation initiator: recovers the unknown B operand S of a
// WIDTH-bit unsigned A<=B comparator by issuing WIDTH trial operands MSB
// first and keeping each trial bit whose comparison answers lteq=1.
module sar_lteq_search
    import sar_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    sar_lteq_search_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                timeout_err
);
    localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic             tmo_clear;
    logic             tmo_enable;
    logic             tmo_hit;

    // The wait counter restarts with every trial and only runs while a
    // response is outstanding.
    assign tmo_clear  = (state == ISSUE);
    assign tmo_enable = (state == WAIT) && !bus.rsp_valid;

    sar_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .hit    (tmo_hit)
    );

    // Search FSM with registered request and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            idx           <= IDX_TOP;
            bus.req_valid <= 1'b0;
            bus.req_a     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            timeout_err   <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Trial bit is ORed in: bits below idx of acc are still
                    // zero, so there is no carry into the kept prefix.
                    bus.req_a     <= acc | (WIDTH'(1) << idx);
                    bus.req_valid <= 1'b1;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (bus.rsp_valid) begin
                        acc[idx]      <= bus.rsp_lteq;
                        bus.req_valid <= 1'b0;
                        if (idx == '0) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx - IDX_W'(1);
                            state <= ISSUE;
                        end
                    end else if (tmo_hit) begin
                        bus.req_valid <= 1'b0;
                        state         <= ERR;
                    end
                end
                DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    timeout_err <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sar_lteq_search.md
Name: sar_lteq_search

Overview:
- Sequential successive-approximation initiator for the 32-bit unsigned less-or-equal comparator datapath.
- Drives trial operand A onto a comparator whose B operand holds an unknown value S.
- Reads back the single result bit (A <= S) and rebuilds S MSB-first in WIDTH comparison rounds.
- Sits upstream of the comparator as its requester; the comparator side of the interface is the responder.

Parameters:
- WIDTH, 32: operand width in bits; the search takes WIDTH rounds.
- TIMEOUT, 15: maximum cycles to wait for a response per round; 0 disables the timeout; counter is 4 bits at default, sized with $clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins a search; ignored unless the FSM is IDLE.
- req_valid  out  1  trial operand valid to the comparator.
- req_a  out  WIDTH  trial operand A.
- rsp_valid  in  1  comparator result valid. Sampled only in WAIT.
- rsp_lteq  in  1  comparator result, 1 means req_a <= S.
- busy  out  1  high from start acceptance until DONE or ERR is exited.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  reconstructed S; holds until the next accepted start.
- timeout_err  out  1  one-cycle pulse when a round times out.

Behaviour:
- Reset values: FSM=IDLE, req_valid=0, req_a=0, busy=0, done=0, result=0, timeout_err=0, bit index=WIDTH-1, timeout counter=0.
- Asynchronous reset mid-search aborts immediately. No done or timeout_err pulse is produced.
- IDLE: if start=1, clear acc to 0, set idx=WIDTH-1, set busy=1, go to ISSUE.
- ISSUE (1 cycle): req_a = acc | (1<<idx), req_valid=1, clear the timeout counter, go to WAIT.
- WAIT:
  - req_valid stays 1 and req_a stays stable until rsp_valid=1.
  - On rsp_valid: if rsp_lteq=1, acc[idx] is set to 1; otherwise it stays 0. req_valid drops in the next cycle.
  - If idx==0, go to DONE. Otherwise decrement idx and go to ISSUE.
  - A response arriving in the same cycle as ISSUE is not sampled; only WAIT samples rsp_valid.
- Timeout: while TIMEOUT!=0 and in WAIT without rsp_valid, the counter increments each cycle.
  - When the counter reaches TIMEOUT and rsp_valid=0, go to ERR.
  - rsp_valid in the same cycle the counter reaches TIMEOUT wins; no error is raised.
- DONE (1 cycle): result<=acc, done=1, busy=0 on exit, return to IDLE.
- ERR (1 cycle): timeout_err=1, result is left unchanged, busy=0 on exit, return to IDLE.
- start while busy is ignored (no restart, no queue).
- start in the same cycle as the DONE/ERR cycle is ignored. start in the following IDLE cycle is accepted.
- Latency with zero-wait responses (rsp_valid in the first WAIT cycle):
  - 2 cycles per round.
  - done asserts 2*WIDTH+1 cycles after the start edge, i.e. 65 at the default.
- Arithmetic:
  - Unsigned throughout.
  - Trial bit is set with OR, never by addition, so there is no carry and no wrap.
  - S=2^WIDTH-1 gives every round lteq=1; S=0 gives every round lteq=0.
- Invariant: in WAIT, req_a[idx-1:0]==0 and req_a[WIDTH-1:idx+1]==acc[WIDTH-1:idx+1].

Decomposition:
- Shared package sar_pkg: state enum (IDLE, ISSUE, WAIT, DONE, ERR), the default WIDTH constant, and a localparam function for the timeout counter width.
- One natural sub-module: sar_timeout_ctr (clear, enable, hit output), reusable by other request/response initiators.
- The bit-index decrement and trial-OR logic stay inline.
- Bench responder: a behavioural model computing lteq = (req_a <= S), with a programmable response delay.

Test Plan:
- S=0xA5A5_5A5A, zero-delay responder, pulse start -> done at cycle 65 after start, result=0xA5A5_5A5A, timeout_err never asserts.
- S=0x0000_0000, then S=0xFFFF_FFFF, back-to-back searches -> results 0x0 and 0xFFFF_FFFF. First trial req_a=0x8000_0000 in both; last trial req_a=0x1 and 0xFFFF_FFFF respectively.
- S=0x1234_5678 with random response delay 0..14 cycles (TIMEOUT=15) -> result=0x1234_5678. req_a stable while req_valid=1 and rsp_valid=0. No timeout.
- Responder withholds rsp_valid in round 3 -> timeout_err pulses exactly TIMEOUT cycles into WAIT, busy drops, result keeps the prior value. Then rsp_valid in exactly the cycle the counter reaches TIMEOUT -> no error, search completes.
- start re-pulsed at cycles 10 and 40 during a search -> ignored, single done pulse, correct result.
- rst_n asserted low asynchronously mid-WAIT at round 17 -> all outputs return to reset values without waiting for a clock edge, no done pulse. A new start after release produces the correct result.
